// File: rtl/ysyx_24100006_mem_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
// Covers the FSM state encoding, the grant IDs and the registered request bundle.
package ysyx_24100006_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  // A timed-out transaction returns this value as its read data.
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

endpackage

// File: rtl/ysyx_24100006_mem_arb_if.sv
// Bundle of the IFU, LSU and pmem handshake signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the cores/pmem side.
interface ysyx_24100006_mem_arb_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  logic        resp_err;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output resp_err
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  resp_err
  );
endinterface

// File: rtl/ysyx_24100006_rr_arb2.sv
// Two-way round-robin tie-break: bit 0 = IFU, bit 1 = LSU, one-hot grant.
// On a tie the master that did not win last time is chosen.
module ysyx_24100006_rr_arb2
  import ysyx_24100006_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == GNT_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_24100006_mem_arb.sv
// Arbitrates the IFU and LSU onto one pmem port, one transaction at a time,
// with a WAIT-state timeout that answers with resp_err=1 and zero data.
module ysyx_24100006_mem_arb
  import ysyx_24100006_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // Handshake: a request transfers on a rising edge where valid && ready;
  // responses are single-cycle strobes with no back-pressure.
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        resp_err,
  output logic [1:0]  state_dbg
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_nx;
  mem_req_t   req_q, req_sel;
  logic       gnt_q, last_grant, err_q;
  logic [7:0] cnt;
  logic [1:0] gnt_oh;
  logic       accept, resp_hit, timeout, done;

  ysyx_24100006_rr_arb2 u_rr (
    .req        ({lsu_req_valid, ifu_req_valid}),
    .last_grant (last_grant),
    .gnt        (gnt_oh)
  );

  assign accept   = (state == ST_IDLE) && (gnt_oh != 2'b00);
  assign resp_hit = (state == ST_WAIT) && mem_resp_valid;
  assign timeout  = (state == ST_WAIT) && (cnt == TO_LAST);
  assign done     = resp_hit || timeout;

  always_comb begin
    req_sel = '0;
    if (gnt_oh[1]) begin
      req_sel.addr  = lsu_addr;
      req_sel.wen   = lsu_wen;
      req_sel.wdata = lsu_wdata;
      req_sel.wmask = lsu_wmask;
    end else begin
      req_sel.addr  = ifu_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept)        state_nx = ST_REQ;
      ST_REQ:  if (mem_req_ready) state_nx = ST_WAIT;
      ST_WAIT: if (done)          state_nx = ST_RESP;
      ST_RESP:                    state_nx = ST_IDLE;
      default:                    state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ifu_req_ready  = (state == ST_IDLE) && gnt_oh[0];
    lsu_req_ready  = (state == ST_IDLE) && gnt_oh[1];
    mem_req_valid  = (state == ST_REQ);
    ifu_resp_valid = (state == ST_RESP) && (gnt_q == GNT_IFU);
    lsu_resp_valid = (state == ST_RESP) && (gnt_q == GNT_LSU);
    resp_err       = (state == ST_RESP) && err_q;
    mem_addr       = req_q.addr;
    mem_wen        = req_q.wen;
    mem_wdata      = req_q.wdata;
    mem_wmask      = req_q.wmask;
    state_dbg      = state;
  end

  // A response landing in the timeout cycle takes priority over the error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      gnt_q      <= GNT_IFU;
      last_grant <= GNT_LSU;
      cnt        <= 8'd0;
      err_q      <= 1'b0;
      ifu_rdata  <= 32'h0;
      lsu_rdata  <= 32'h0;
    end else begin
      if (accept) begin
        req_q      <= req_sel;
        gnt_q      <= gnt_oh[1] ? GNT_LSU : GNT_IFU;
        last_grant <= gnt_oh[1] ? GNT_LSU : GNT_IFU;
      end
      cnt <= (state == ST_WAIT) ? cnt + 8'd1 : 8'd0;
      if (done) begin
        err_q <= !resp_hit;
        if (gnt_q == GNT_IFU) ifu_rdata <= resp_hit ? mem_rdata : ERR_RDATA;
        else                  lsu_rdata <= resp_hit ? mem_rdata : ERR_RDATA;
      end
    end
  end

endmodule
